mux_pkt_arbiter: RTL and testbench
==================================

// Module: mux_pkt_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sitting directly upstream of the 2:1 output
//  mux; drives its one-hot sel. Locks the grant from head flit to tail flit.
//  Gates forwarding on a downstream credit counter, one credit per buffer slot.
//  Returns per-input grant pulses so senders advance only on accepted flits.
//  sel all-zero means no input is selected: mux ovalid is 0.
// PARAMETERS
//  PORT_W   5   width of sel; bit k selects input k (only bits 0,1 used)
//  TYPE_W   2   flit type field width (flit MSBs)
//  CREDITS  4   downstream buffer depth = reset credit count (1..15)
//  CNT_W    4   credit counter width; must hold CREDITS
// PORTS
//  clk        in   1        clock, rising edge
//  rst_       in   1        asynchronous reset, active low
//  ivalid_0   in   1        input 0 flit valid
//  itype_0    in   TYPE_W   input 0 flit type: 00 NONE, 01 HEAD, 10 DATA, 11 TAIL
//  ivalid_1   in   1        input 1 flit valid
//  itype_1    in   TYPE_W   input 1 flit type
//  credit_in  in   1        downstream freed one slot (1-cycle pulse)
//  sel        out  PORT_W   one-hot mux select, all-zero = none (combinational)
//  grant_0    out  1        input 0 flit forwarded this cycle (combinational)
//  grant_1    out  1        input 1 flit forwarded this cycle (combinational)
//  credit_cnt out  CNT_W    current credit count (registered)
//  busy       out  1        packet lock held (state != IDLE)
//  proto_err  out  1        sticky: non-HEAD valid flit seen on an unlocked input
//  cred_ovf   out  1        sticky: credit_in while credit_cnt == CREDITS
// BEHAVIOUR
//  Reset (rst_ low, async):
//   - state IDLE, rr_ptr=0 (input 0 has priority), credit_cnt=CREDITS.
//   - proto_err=0, cred_ovf=0.
//   - sel, grant_* forced 0 while rst_ low.
//  Zero-latency grant: sel/grant_k are combinational from registered state and current inputs.
//  fwd = credit_cnt>0 and a selected input is valid. grant_k=1 iff sel[k]=1.
//  FSM:
//   - IDLE: candidates are inputs with ivalid=1 and itype=HEAD.
//     Winner = rr_ptr if it is a candidate, else the other input.
//     If a winner exists and credit_cnt>0: sel[winner]=1, next state LOCK_winner.
//     If credit_cnt==0: no grant, state stays IDLE.
//   - LOCK_k: sel[k]=1 iff ivalid_k=1 and credit_cnt>0.
//     Bubbles (ivalid_k=0) hold the lock; the other input is never granted.
//     Forwarded TAIL: next state IDLE, rr_ptr=~k.
//     Forwarded HEAD while locked: forwarded as data, proto_err set.
//  Credits: credit_cnt_next = credit_cnt - fwd + credit_in.
//   - fwd and credit_in in the same cycle: count unchanged.
//   - credit_in at CREDITS (no fwd): count held at CREDITS, cred_ovf set.
//   - Count never underflows: fwd requires credit_cnt>0.
//  proto_err is set when, in IDLE, any valid input carries DATA or TAIL.
//   - That flit is not granted; the input stalls.
//  itype=NONE with ivalid=1 in IDLE: ignored, no error.
//  Sticky flags clear only on reset.
//  Reset mid-packet: lock dropped, credits restored to CREDITS; the next packet must start with HEAD.
// TESTING
//  T1 reset: rst_ low with ivalid_0=1/HEAD -> sel=0, grant_0=0, credit_cnt=4, busy=0, flags 0.
//  T2 single packet: input1 sends HEAD, 20 DATA, TAIL back-to-back, credit_in=1 every cycle
//     -> sel=5'b00010 for 22 consecutive cycles, grant_1=1 each cycle, busy drops after TAIL.
//  T3 contention: both inputs HEAD on the same cycle after reset.
//     -> input0 wins; input1 is held with grant_1=0 through input0's TAIL.
//     -> input1 is then granted the next cycle; on the next tie, input0 wins again.
//  T4 credit stall: CREDITS=4, no credit_in, 10-flit packet on input0.
//     -> 4 grants, then sel=0 with credit_cnt=0.
//     -> each single credit_in pulse gives exactly one grant on the following cycle.
//  T5 protocol: DATA flit valid on input1 in IDLE -> no grant, proto_err=1 and stays 1.
//     -> extra credit_in at credit_cnt=4 -> cred_ovf=1, credit_cnt remains 4.
//  T6 reset mid-packet: pulse rst_ after 5 flits of an input1 packet.
//     -> busy=0, credit_cnt=4, rr_ptr=0; DATA flits then raise proto_err; a fresh HEAD is granted.

Source files
------------

// File: rtl/mux_pkt_arbiter.sv
// Packet-granular round-robin arbiter for a 2:1 output mux: locks one input from HEAD to TAIL,
// forwards only while downstream credits remain, and reports protocol/credit errors as sticky flags.
module mux_pkt_arbiter #(
  parameter int unsigned PORT_W  = 5,
  parameter int unsigned TYPE_W  = 2,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              ivalid_0,
  input  logic [TYPE_W-1:0] itype_0,
  input  logic              ivalid_1,
  input  logic [TYPE_W-1:0] itype_1,
  input  logic              credit_in,
  output logic [PORT_W-1:0] sel,
  output logic              grant_0,
  output logic              grant_1,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic              busy,
  output logic              proto_err,
  output logic              cred_ovf
);

  localparam logic [TYPE_W-1:0] T_HEAD = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] T_DATA = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] T_TAIL = TYPE_W'(3);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CREDITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_0 = 2'd1,
    LOCK_1 = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic                rr_ptr, rr_nx;
  logic [CNT_W-1:0]    cnt_nx;
  logic                perr_nx, ovf_nx;
  logic [PORT_W-1:0]   sel_c;
  logic [1:0]          valid;
  logic [1:0]          cand;
  logic [TYPE_W-1:0]   ftype [2];
  logic                own;
  logic                fwd;
  logic                has_cred;

  assign valid    = {ivalid_1, ivalid_0};
  assign ftype[0] = itype_0;
  assign ftype[1] = itype_1;
  assign has_cred = (credit_cnt != '0);

  // Arbitration, lock tracking and credit accounting
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    cnt_nx   = credit_cnt;
    perr_nx  = proto_err;
    ovf_nx   = cred_ovf;
    sel_c    = '0;
    cand     = '0;
    own      = 1'b0;
    fwd      = 1'b0;

    case (state)
      IDLE: begin
        for (int k = 0; k < 2; k++) begin
          cand[k] = valid[k] && (ftype[k] == T_HEAD);
          if (valid[k] && ((ftype[k] == T_DATA) || (ftype[k] == T_TAIL)))
            perr_nx = 1'b1;
        end
        if ((cand != 2'b00) && has_cred) begin
          own = cand[rr_ptr] ? rr_ptr : ~rr_ptr;
          if (own) sel_c[1] = 1'b1;
          else     sel_c[0] = 1'b1;
          state_nx = own ? LOCK_1 : LOCK_0;
        end
      end
      LOCK_0, LOCK_1: begin
        own = (state == LOCK_1);
        if (valid[own] && has_cred) begin
          if (own) sel_c[1] = 1'b1;
          else     sel_c[0] = 1'b1;
          if (ftype[own] == T_TAIL) begin
            state_nx = IDLE;
            rr_nx    = ~own;
          end
          if (ftype[own] == T_HEAD) perr_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Reset asserted overrides the combinational grant path
    if (!rst_) sel_c = '0;
    fwd = (sel_c != '0);

    case ({fwd, credit_in})
      2'b10:   cnt_nx = credit_cnt - CNT_W'(1);
      2'b01: begin
        if (credit_cnt == CNT_MAX) ovf_nx = 1'b1;
        else                       cnt_nx = credit_cnt + CNT_W'(1);
      end
      default: cnt_nx = credit_cnt;
    endcase
  end

  assign sel     = sel_c;
  assign grant_0 = sel_c[0];
  assign grant_1 = sel_c[1];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      credit_cnt <= CNT_MAX;
      proto_err  <= 1'b0;
      cred_ovf   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      rr_ptr     <= rr_nx;
      credit_cnt <= cnt_nx;
      proto_err  <= perr_nx;
      cred_ovf   <= ovf_nx;
      busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// Directed bench for mux_pkt_arbiter: packet-level reference model checked every cycle,
// plus literal expectations for the reset, streaming, contention, credit and error scenarios.
module tb_mux_pkt_arbiter;

  localparam int CREDITS = 4;
  localparam logic [1:0] NONE = 2'd0, HEAD = 2'd1, DATA = 2'd2, TAIL = 2'd3;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       ivalid_0 = 1'b0, ivalid_1 = 1'b0, credit_in = 1'b0;
  logic [1:0] itype_0 = NONE, itype_1 = NONE;
  logic [4:0] sel;
  logic       grant_0, grant_1, busy, proto_err, cred_ovf;
  logic [3:0] credit_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  mux_pkt_arbiter #(.PORT_W(5), .TYPE_W(2), .CREDITS(CREDITS), .CNT_W(4)) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .credit_in(credit_in),
    .sel(sel), .grant_0(grant_0), .grant_1(grant_1),
    .credit_cnt(credit_cnt), .busy(busy),
    .proto_err(proto_err), .cred_ovf(cred_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: owner of the packet lock (-1 = none), round-robin favourite, credits, flags
  int m_owner = -1, m_rr = 0, m_cred = CREDITS;
  int n_owner = -1, n_rr = 0, n_cred = CREDITS;
  bit m_perr = 0, m_ovf = 0, n_perr = 0, n_ovf = 0;

  always @(negedge clk) begin
    int e_sel, w, v[2], t[2];
    bit c0, c1;
    v[0] = int'(ivalid_0); v[1] = int'(ivalid_1);
    t[0] = int'(itype_0);  t[1] = int'(itype_1);
    if (!rst_) begin
      m_owner = -1; m_rr = 0; m_cred = CREDITS; m_perr = 0; m_ovf = 0;
    end
    e_sel = 0;
    n_owner = m_owner; n_rr = m_rr; n_perr = m_perr; n_ovf = m_ovf;
    if (rst_) begin
      if (m_owner < 0) begin
        c0 = (v[0] == 1) && (t[0] == 1);
        c1 = (v[1] == 1) && (t[1] == 1);
        if ((v[0] == 1 && t[0] >= 2) || (v[1] == 1 && t[1] >= 2)) n_perr = 1;
        if (m_cred > 0 && (c0 || c1)) begin
          if (m_rr == 0) w = c0 ? 0 : 1;
          else           w = c1 ? 1 : 0;
          e_sel = 1 << w;
          n_owner = w;
        end
      end else if (v[m_owner] == 1 && m_cred > 0) begin
        e_sel = 1 << m_owner;
        if (t[m_owner] == 3) begin n_owner = -1; n_rr = 1 - m_owner; end
        if (t[m_owner] == 1) n_perr = 1;
      end
    end
    n_cred = m_cred - (e_sel != 0 ? 1 : 0) + int'(credit_in);
    if (n_cred > CREDITS) begin n_cred = CREDITS; n_ovf = 1; end
    if (!rst_) begin
      n_owner = -1; n_rr = 0; n_cred = CREDITS; n_perr = 0; n_ovf = 0;
    end
    chk("sel", int'(sel), e_sel);
    chk("grant_0", int'(grant_0), e_sel & 1);
    chk("grant_1", int'(grant_1), (e_sel >> 1) & 1);
    chk("credit_cnt", int'(credit_cnt), m_cred);
    chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
    chk("proto_err", int'(proto_err), int'(m_perr));
    chk("cred_ovf", int'(cred_ovf), int'(m_ovf));
  end

  always @(posedge clk) begin
    m_owner <= n_owner; m_rr <= n_rr; m_cred <= n_cred;
    m_perr <= n_perr;   m_ovf <= n_ovf;
  end

  // One cycle of stimulus; returns with outputs settled at the falling edge
  task automatic apply(input logic v0, input logic [1:0] t0,
                       input logic v1, input logic [1:0] t1, input logic cin);
    @(posedge clk); #1;
    ivalid_0 = v0; itype_0 = t0; ivalid_1 = v1; itype_1 = t1; credit_in = cin;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_ = 1'b0;
    ivalid_0 = 1'b0; ivalid_1 = 1'b0; credit_in = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_credit", int'(credit_cnt), 4);
    @(posedge clk); #1;
    rst_ = 1'b1;
  endtask

  initial begin
    int idx;
    logic [1:0] ft;

    // T1: reset held with a HEAD offered
    ivalid_0 = 1'b1; itype_0 = HEAD;
    @(negedge clk);
    chk("t1_sel", int'(sel), 0);
    chk("t1_grant_0", int'(grant_0), 0);
    chk("t1_credit", int'(credit_cnt), 4);
    chk("t1_busy", int'(busy), 0);
    chk("t1_flags", int'({proto_err, cred_ovf}), 0);
    @(posedge clk); #1;
    rst_ = 1'b1; ivalid_0 = 1'b0; itype_0 = NONE;

    // T2: 22-flit packet on input 1, credit returned every cycle
    for (int i = 0; i < 22; i++) begin
      ft = (i == 0) ? HEAD : (i == 21) ? TAIL : DATA;
      apply(1'b0, NONE, 1'b1, ft, 1'b1);
      chk("t2_sel", int'(sel), 2);
      chk("t2_grant_1", int'(grant_1), 1);
    end
    apply(1'b0, NONE, 1'b0, NONE, 1'b0);
    chk("t2_busy_drop", int'(busy), 0);
    chk("t2_credit", int'(credit_cnt), 4);

    // T3: contention, round-robin alternation
    reset_pulse();
    apply(1'b1, HEAD, 1'b1, HEAD, 1'b1);
    chk("t3_tie_sel", int'(sel), 1);
    chk("t3_tie_g1", int'(grant_1), 0);
    apply(1'b1, DATA, 1'b1, HEAD, 1'b1);
    chk("t3_hold_g1", int'(grant_1), 0);
    apply(1'b1, TAIL, 1'b1, HEAD, 1'b1);
    chk("t3_tail_g0", int'(grant_0), 1);
    chk("t3_tail_g1", int'(grant_1), 0);
    apply(1'b0, NONE, 1'b1, HEAD, 1'b1);
    chk("t3_next_sel", int'(sel), 2);
    apply(1'b0, NONE, 1'b1, TAIL, 1'b1);
    chk("t3_tail1_g1", int'(grant_1), 1);
    apply(1'b1, HEAD, 1'b1, HEAD, 1'b1);
    chk("t3_tie2_sel", int'(sel), 1);
    apply(1'b1, TAIL, 1'b0, NONE, 1'b1);
    chk("t3_tail2_g0", int'(grant_0), 1);

    // T4: credit stall on a 10-flit packet
    reset_pulse();
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      ft = (idx == 0) ? HEAD : DATA;
      apply(1'b1, ft, 1'b0, NONE, 1'b0);
      chk("t4_grant", int'(grant_0), 1);
      if (grant_0) idx++;
    end
    apply(1'b1, DATA, 1'b0, NONE, 1'b0);
    chk("t4_stall_sel", int'(sel), 0);
    chk("t4_stall_cnt", int'(credit_cnt), 0);
    while (idx < 10) begin
      ft = (idx == 9) ? TAIL : DATA;
      apply(1'b1, ft, 1'b0, NONE, 1'b1);
      chk("t4_pulse_nogrant", int'(grant_0), 0);
      apply(1'b1, ft, 1'b0, NONE, 1'b0);
      chk("t4_pulse_grant", int'(grant_0), 1);
      if (grant_0) idx++;
      else idx = 10;
    end
    apply(1'b0, NONE, 1'b0, NONE, 1'b0);
    chk("t4_done_busy", int'(busy), 0);
    chk("t4_done_cnt", int'(credit_cnt), 0);

    // T5: protocol error and credit overflow
    reset_pulse();
    apply(1'b0, NONE, 1'b1, DATA, 1'b0);
    chk("t5_data_nogrant", int'(sel), 0);
    apply(1'b0, NONE, 1'b1, DATA, 1'b0);
    chk("t5_perr", int'(proto_err), 1);
    apply(1'b1, NONE, 1'b0, NONE, 1'b0);
    chk("t5_none_sel", int'(sel), 0);
    apply(1'b0, NONE, 1'b0, NONE, 1'b1);
    chk("t5_perr_sticky", int'(proto_err), 1);
    apply(1'b0, NONE, 1'b0, NONE, 1'b0);
    chk("t5_ovf", int'(cred_ovf), 1);
    chk("t5_ovf_cnt", int'(credit_cnt), 4);

    // T6: reset in the middle of a packet
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, NONE, 1'b1, (i == 0) ? HEAD : DATA, 1'b1);
      chk("t6_pre_g1", int'(grant_1), 1);
    end
    @(posedge clk); #1;
    rst_ = 1'b0; ivalid_1 = 1'b1; itype_1 = DATA; credit_in = 1'b0;
    @(negedge clk);
    chk("t6_rst_sel", int'(sel), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_perr", int'(proto_err), 0);
    @(posedge clk); #1;
    rst_ = 1'b1;
    @(negedge clk);
    chk("t6_data_nogrant", int'(grant_1), 0);
    chk("t6_credit", int'(credit_cnt), 4);
    apply(1'b1, HEAD, 1'b1, HEAD, 1'b0);
    chk("t6_rr0_sel", int'(sel), 1);
    chk("t6_perr", int'(proto_err), 1);
    apply(1'b1, TAIL, 1'b1, HEAD, 1'b0);
    chk("t6_tail_g0", int'(grant_0), 1);
    apply(1'b0, NONE, 1'b1, HEAD, 1'b0);
    chk("t6_head_g1", int'(grant_1), 1);
    apply(1'b0, NONE, 1'b1, TAIL, 1'b0);
    chk("t6_tail_g1", int'(grant_1), 1);
    apply(1'b0, NONE, 1'b0, NONE, 1'b0);
    chk("t6_end_busy", int'(busy), 0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
